// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory:
// funct3 access codes and the store byte-enable type.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [3:0] byte_en_t;

    // Lanes written by a store; undefined funct3 writes none.
    function automatic byte_en_t store_en(
        input logic [2:0] f3,
        input logic [1:0] lane
    );
        byte_en_t en;
        en = 4'b0000;
        case (f3)
            F3_B:    en = 4'b0001 << lane;
            F3_H:    en = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:    en = 4'b1111;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment: selects byte/halfword/word from a
// memory word and sign- or zero-extends it per funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*lane +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = 32'h0;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            F3_W:    result = word;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the MEM stage:
// stores commit on the clock edge, loads are combinational.
module data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] dataW,
    input  logic [2:0]  funct3,
    input  logic        MemRW,
    output logic [31:0] dataR
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   memory [DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    byte_en_t      be;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic          unused_addr;

    assign idx         = addr[AW+1:2];
    assign lane        = addr[1:0];
    assign unused_addr = ^addr[31:AW+2];

    // Replicate store data across lanes so each enable picks its own byte.
    always_comb begin
        be    = store_en(funct3, lane);
        wdata = dataW;
        case (funct3)
            F3_B:    wdata = {4{dataW[7:0]}};
            F3_H:    wdata = {2{dataW[15:0]}};
            default: wdata = dataW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                memory[i] <= 32'h0;
            end
        end else if (MemRW) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    memory[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rword = memory[idx];

    load_extend u_load_extend (
        .word   (rword),
        .lane   (lane),
        .funct3 (funct3),
        .result (dataR)
    );

endmodule

// File: tb/tb_data_memory.sv
// Directed scoreboard bench for data_memory: expected load
// results are queued with each step and popped when checked.
module tb_data_memory;
    import mem_pkg::*;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] dataW;
    logic [2:0]  funct3;
    logic        MemRW;
    logic [31:0] dataR;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_cmp;
    int          n_bad;

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .dataW  (dataW),
        .funct3 (funct3),
        .MemRW  (MemRW),
        .dataR  (dataR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string t, input logic [31:0] e);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic chk();
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (dataR === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", t, dataR, e);
        end
    endtask

    task automatic load(input string t, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] e);
        MemRW  = 1'b0;
        funct3 = f3;
        addr   = a;
        expect_val(t, e);
        #1;
        chk();
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        MemRW  = 1'b1;
        funct3 = f3;
        addr   = a;
        dataW  = d;
        @(posedge clk);
        #1;
        MemRW  = 1'b0;
    endtask

    // Word store that checks dataR before and after its own edge.
    task automatic store_rw(input string t, input logic [31:0] a,
                            input logic [31:0] oldv, input logic [31:0] d);
        MemRW  = 1'b1;
        funct3 = F3_W;
        addr   = a;
        dataW  = d;
        expect_val({t, "_before"}, oldv);
        #1;
        chk();
        expect_val({t, "_after"}, d);
        @(posedge clk);
        #1;
        chk();
        MemRW  = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        MemRW  = 1'b0;
        addr   = 32'h0;
        dataW  = 32'h0;
        funct3 = F3_W;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        load("reset_lw08", F3_W, 32'h08, 32'h0);
        load("reset_lw3fc", F3_W, 32'h3FC, 32'h0);

        store(F3_W, 32'h08, 32'h12345678);
        store(F3_B, 32'h09, 32'h123456AB);
        store(F3_H, 32'h0A, 32'h9999FACE);
        load("lw08_merge", F3_W, 32'h08, 32'hFACEAB78);
        load("lb09", F3_B, 32'h09, 32'hFFFFFFAB);
        load("lbu09", F3_BU, 32'h09, 32'h000000AB);
        load("lh0a", F3_H, 32'h0A, 32'hFFFFFACE);
        load("lhu0a", F3_HU, 32'h0A, 32'h0000FACE);
        load("lb08", F3_B, 32'h08, 32'h00000078);
        load("lh0b_align", F3_H, 32'h0B, 32'hFFFFFACE);
        load("lh08", F3_H, 32'h08, 32'hFFFFAB78);
        load("lhu08", F3_HU, 32'h08, 32'h0000AB78);
        load("lbu0b", F3_BU, 32'h0B, 32'h000000FA);
        load("lundef", 3'b011, 32'h08, 32'h0);

        store_rw("same_cycle", 32'h10, 32'h0, 32'h11111111);
        store(3'b011, 32'h10, 32'hFFFFFFFF);
        store(3'b111, 32'h10, 32'hFFFFFFFF);
        load("undef_store", F3_W, 32'h10, 32'h11111111);

        rst_n  = 1'b0;
        MemRW  = 1'b1;
        funct3 = F3_W;
        addr   = 32'h08;
        dataW  = 32'hCAFEBABE;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        MemRW = 1'b0;
        load("rst_store_08", F3_W, 32'h08, 32'h0);
        load("rst_clear_10", F3_W, 32'h10, 32'h0);

        store(F3_W, 32'h0B, 32'hDEADBEEF);
        load("sw_misalign", F3_W, 32'h08, 32'hDEADBEEF);
        store(F3_W, DEPTH * 4 + 32'h08, 32'h0BADF00D);
        load("sw_wrap", F3_W, 32'h08, 32'h0BADF00D);
        load("lw_wrap_addr", F3_W, DEPTH * 4 + 32'h08, 32'h0BADF00D);
        load("wrap_neighbor", F3_W, 32'h0C, 32'h0);

        store(F3_B, 32'h20, 32'h00000011);
        store(F3_B, 32'h21, 32'h00000022);
        load("b2b_sb", F3_W, 32'h20, 32'h00002211);
        store(F3_H, 32'h23, 32'h00003344);
        load("sh_upper", F3_W, 32'h20, 32'h33442211);
        load("lb_last", F3_B, 32'h23, 32'h00000033);

        store_rw("top_word", 32'h3FC, 32'h0, 32'h80000001);
        load("lh_top_neg", F3_H, 32'h3FE, 32'hFFFF8000);

        if (exp_q.size() != 0) begin
            n_bad++;
            $error("FAIL scoreboard_drain: observed %0d expected 0",
                   exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
